// File: rtl/bram_deep_w_ctrl.sv
// Sequencer for the deep-write / wide-read BRAM stack feeding the MLP column:
// fills BRAM 0..M-1 from a 64-bit stream, then sweeps the shared read address.
module bram_deep_w_ctrl #(
    parameter int M        = 6,
    parameter int WR_DEPTH = 1024,
    parameter int RD_LAT   = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start_load,
    input  logic [63:0] i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    output logic [63:0] o_wrdata,
    output logic [9:0]  o_wraddr,
    output logic [6:0]  o_wrblk_addr,
    output logic        o_wren,
    input  logic        i_start_read,
    input  logic [8:0]  i_rd_last_addr,
    output logic [8:0]  o_rdaddr,
    output logic        o_rd_valid,
    output logic        o_rd_first,
    output logic        o_rd_last,
    output logic        o_load_done,
    output logic        o_busy
);

    localparam int DCW = $clog2(RD_LAT + 2);

    typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;

    state_t          state;
    logic [9:0]      wcnt;
    logic [6:0]      blk;
    logic [8:0]      rcnt;
    logic [8:0]      last_addr_q;
    logic [DCW-1:0]  dcnt;
    logic [RD_LAT:0] vld_pipe;
    logic [RD_LAT:0] fst_pipe;
    logic [RD_LAT:0] lst_pipe;

    logic       beat;
    logic       wr_final;
    logic       issue;
    logic [8:0] iss_addr;
    logic [8:0] iss_last_ref;
    logic       iss_first;
    logic       iss_last;

    assign o_wr_ready = (state == LOAD);
    assign o_busy     = (state != IDLE);
    assign beat       = i_wr_valid && (state == LOAD);
    assign wr_final   = (wcnt == 10'(WR_DEPTH - 1)) && (blk == 7'(M - 1));

    // Issue decision: the start edge itself issues row 0 so the sweep begins
    // on the cycle right after the start pulse.
    always_comb begin
        issue        = 1'b0;
        iss_addr     = rcnt;
        iss_last_ref = last_addr_q;
        if (state == IDLE && i_start_read && !i_start_load) begin
            issue        = 1'b1;
            iss_addr     = '0;
            iss_last_ref = i_rd_last_addr;
        end else if (state == READ) begin
            issue = 1'b1;
        end
        iss_first = issue && (iss_addr == 9'd0);
        iss_last  = issue && (iss_addr == iss_last_ref);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            wcnt         <= '0;
            blk          <= '0;
            rcnt         <= '0;
            last_addr_q  <= '0;
            dcnt         <= '0;
            o_wren       <= 1'b0;
            o_wrdata     <= '0;
            o_wraddr     <= '0;
            o_wrblk_addr <= '0;
            o_load_done  <= 1'b0;
            o_rdaddr     <= '0;
        end else begin
            o_wren      <= beat;
            o_load_done <= beat && wr_final;
            if (beat) begin
                o_wrdata     <= i_wr_data;
                o_wraddr     <= wcnt;
                o_wrblk_addr <= blk;
            end
            if (issue)
                o_rdaddr <= iss_addr;

            case (state)
                IDLE: begin
                    if (i_start_load) begin
                        state <= LOAD;
                        wcnt  <= '0;
                        blk   <= '0;
                    end else if (i_start_read) begin
                        last_addr_q <= i_rd_last_addr;
                        rcnt        <= 9'd1;
                        dcnt        <= '0;
                        state       <= iss_last ? DRAIN : READ;
                    end
                end
                // Even/odd write words land in low/high halves of one read row
                // inside the stack; the sequencer only walks linear addresses.
                LOAD: begin
                    if (beat) begin
                        if (wcnt == 10'(WR_DEPTH - 1)) begin
                            wcnt <= '0;
                            if (blk == 7'(M - 1)) begin
                                blk   <= '0;
                                state <= IDLE;
                            end else begin
                                blk <= blk + 7'd1;
                            end
                        end else begin
                            wcnt <= wcnt + 10'd1;
                        end
                    end
                end
                READ: begin
                    rcnt <= rcnt + 9'd1;
                    if (iss_last) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    if (dcnt == DCW'(RD_LAT))
                        state <= IDLE;
                    else
                        dcnt <= dcnt + DCW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read flag pipe: stage 0 aligns with o_rdaddr, stage RD_LAT with MLP data.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_pipe <= '0;
            fst_pipe <= '0;
            lst_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:0], issue};
            fst_pipe <= {fst_pipe[RD_LAT-1:0], iss_first};
            lst_pipe <= {lst_pipe[RD_LAT-1:0], iss_last};
        end
    end

    assign o_rd_valid = vld_pipe[RD_LAT];
    assign o_rd_first = fst_pipe[RD_LAT];
    assign o_rd_last  = lst_pipe[RD_LAT];

endmodule

// File: tb/tb_bram_deep_w_ctrl.sv
// Directed bench for bram_deep_w_ctrl with M=2, WR_DEPTH=4, RD_LAT=2.
module tb_bram_deep_w_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_load = 1'b0;
    logic [63:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [63:0] wrdata;
    logic [9:0]  wraddr;
    logic [6:0]  wrblk_addr;
    logic        wren;
    logic        start_read = 1'b0;
    logic [8:0]  rd_last_addr = '0;
    logic [8:0]  rdaddr;
    logic        rd_valid;
    logic        rd_first;
    logic        rd_last;
    logic        load_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_deep_w_ctrl #(.M(2), .WR_DEPTH(4), .RD_LAT(2)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start_load(start_load),
        .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .o_wrdata(wrdata), .o_wraddr(wraddr), .o_wrblk_addr(wrblk_addr),
        .o_wren(wren), .i_start_read(start_read), .i_rd_last_addr(rd_last_addr),
        .o_rdaddr(rdaddr), .o_rd_valid(rd_valid), .o_rd_first(rd_first),
        .o_rd_last(rd_last), .o_load_done(load_done), .o_busy(busy)
    );

    typedef struct {
        logic        sl;
        logic        v;
        logic [63:0] d;
        logic        e_wren;
        logic [9:0]  e_addr;
        logic [6:0]  e_blk;
        logic [63:0] e_data;
        logic        e_done;
        logic        e_rdy;
        logic        e_busy;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic sl, input logic sr, input logic v,
                        input logic [63:0] d, input logic [8:0] la);
        @(negedge clk);
        start_load   = sl;
        start_read   = sr;
        wr_valid     = v;
        wr_data      = d;
        rd_last_addr = la;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wren"}, 64'(wren), 64'd0);
        chk({tag, "_wrdata"}, wrdata, 64'd0);
        chk({tag, "_wraddr"}, 64'(wraddr), 64'd0);
        chk({tag, "_blk"}, 64'(wrblk_addr), 64'd0);
        chk({tag, "_ready"}, 64'(wr_ready), 64'd0);
        chk({tag, "_done"}, 64'(load_done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rdaddr"}, 64'(rdaddr), 64'd0);
        chk({tag, "_rdvalid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_first"}, 64'(rd_first), 64'd0);
        chk({tag, "_last"}, 64'(rd_last), 64'd0);
    endtask

    // Runs a read sweep and checks address, flags and busy for ncyc cycles.
    task automatic read_sweep(input string tag, input logic [8:0] la, input int ncyc);
        int last_n;
        last_n = int'(la) + 1;
        step(1'b0, 1'b1, 1'b0, 64'd0, la);
        for (int n = 1; n <= ncyc; n++) begin
            if (n > 1) step(1'b0, 1'b0, 1'b0, 64'd0, 9'd0);
            chk({tag, "_rdaddr"}, 64'(rdaddr), (n <= last_n) ? 64'(n - 1) : 64'(la));
            chk({tag, "_valid"}, 64'(rd_valid), 64'(n >= 3 && n <= last_n + 2));
            chk({tag, "_first"}, 64'(rd_first), 64'(n == 3));
            chk({tag, "_last"}, 64'(rd_last), 64'(n == last_n + 2));
            chk({tag, "_busy"}, 64'(busy), 64'(n <= last_n + 2));
        end
    endtask

    initial begin
        int nb;
        logic [9:0] prev_addr;
        logic exp_acc;

        // Test 1 table: start pulse, 8 beats of data A0+k, one refused beat.
        tbl[0] = '{1'b1, 1'b0, 64'd0, 1'b0, 10'd0, 7'd0, 64'd0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 8; k++)
            tbl[k+1] = '{1'b0, 1'b1, 64'hA0 + 64'(k), 1'b1, 10'(k % 4), 7'(k / 4),
                         64'hA0 + 64'(k), k == 7, k != 7, k != 7};
        tbl[9] = '{1'b0, 1'b1, 64'hFF, 1'b0, 10'd3, 7'd1, 64'hA7, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: table-driven full load
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].sl, 1'b0, tbl[i].v, tbl[i].d, 9'd0);
            chk($sformatf("t1_wren[%0d]", i), 64'(wren), 64'(tbl[i].e_wren));
            chk($sformatf("t1_addr[%0d]", i), 64'(wraddr), 64'(tbl[i].e_addr));
            chk($sformatf("t1_blk[%0d]", i), 64'(wrblk_addr), 64'(tbl[i].e_blk));
            chk($sformatf("t1_data[%0d]", i), wrdata, tbl[i].e_data);
            chk($sformatf("t1_done[%0d]", i), 64'(load_done), 64'(tbl[i].e_done));
            chk($sformatf("t1_ready[%0d]", i), 64'(wr_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("t1_busy[%0d]", i), 64'(busy), 64'(tbl[i].e_busy));
        end

        // Test 2: valid toggling 1010.., address must advance only on beats
        step(1'b1, 1'b0, 1'b0, 64'd0, 9'd0);
        nb = 0;
        prev_addr = wraddr;
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b0, (i % 2) == 0, 64'hE0 + 64'(i), 9'd0);
            exp_acc = ((i % 2) == 0) && (nb < 8);
            chk($sformatf("t2_wren[%0d]", i), 64'(wren), 64'(exp_acc));
            chk($sformatf("t2_done[%0d]", i), 64'(load_done), 64'(exp_acc && nb == 7));
            if (exp_acc) begin
                chk($sformatf("t2_addr[%0d]", i), 64'(wraddr), 64'(nb % 4));
                chk($sformatf("t2_blk[%0d]", i), 64'(wrblk_addr), 64'(nb / 4));
                chk($sformatf("t2_data[%0d]", i), wrdata, 64'hE0 + 64'(i));
                nb++;
            end else begin
                chk($sformatf("t2_hold[%0d]", i), 64'(wraddr), 64'(prev_addr));
            end
            prev_addr = wraddr;
        end
        chk("t2_ready_after", 64'(wr_ready), 64'd0);
        chk("t2_beats", 64'(nb), 64'd8);

        // Test 3: full 512-row sweep; last_addr input cleared after start
        read_sweep("t3", 9'd511, 516);

        // Test 5: simultaneous starts pick LOAD; read start during LOAD ignored
        step(1'b1, 1'b1, 1'b0, 64'd0, 9'd5);
        chk("t5_ready", 64'(wr_ready), 64'd1);
        chk("t5_rdaddr0", 64'(rdaddr), 64'd511);
        step(1'b0, 1'b1, 1'b0, 64'd0, 9'd5);
        step(1'b0, 1'b0, 1'b0, 64'd0, 9'd0);
        chk("t5_rdaddr1", 64'(rdaddr), 64'd511);
        chk("t5_rdvalid", 64'(rd_valid), 64'd0);
        chk("t5_still_load", 64'(wr_ready), 64'd1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b1, 64'hB0 + 64'(k), 9'd0);
            chk($sformatf("t5_addr[%0d]", k), 64'(wraddr), 64'(k % 4));
            chk($sformatf("t5_blk[%0d]", k), 64'(wrblk_addr), 64'(k / 4));
            chk($sformatf("t5_done[%0d]", k), 64'(load_done), 64'(k == 7));
        end
        step(1'b0, 1'b0, 1'b0, 64'd0, 9'd0);
        chk("t5_idle", 64'(busy), 64'd0);

        // Test 4: single-row sweep
        read_sweep("t4", 9'd0, 6);

        // Test 6: async reset at beat 5, then a fresh load
        step(1'b1, 1'b0, 1'b0, 64'd0, 9'd0);
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, 1'b1, 64'hC0 + 64'(k), 9'd0);
        chk("t6_pre_blk", 64'(wrblk_addr), 64'd1);
        chk("t6_pre_addr", 64'(wraddr), 64'd0);
        chk("t6_pre_wren", 64'(wren), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async");
        @(negedge clk);
        wr_valid = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 64'd0, 9'd0);
        chk("t6_no_done", 64'(load_done), 64'd0);
        step(1'b0, 1'b0, 1'b1, 64'hD0, 9'd0);
        chk("t6_new_wren", 64'(wren), 64'd1);
        chk("t6_new_blk", 64'(wrblk_addr), 64'd0);
        chk("t6_new_addr", 64'(wraddr), 64'd0);
        chk("t6_new_data", wrdata, 64'hD0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
